// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    // Operand width used when the instantiating level does not override it.
    localparam int SUB_WIDTH_DEFAULT = 8;

    // Control FSM states: wait for start, process one bit per cycle, flag result.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout is the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b LSB first, one bit
// per clock, behind a start/done handshake.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [WIDTH-1:0]   a_sr_q,       a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,       b_sr_d;
    logic               borrow_q,     borrow_d;
    logic [WIDTH-1:0]   partial_q,    partial_d;
    logic [WIDTH-1:0]   diff_q,       diff_d;
    logic               borrow_out_q, borrow_out_d;

    logic               cell_d;
    logic               cell_bout;

    // The single arithmetic cell, fed from the LSBs of the operand shifters.
    full_subtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        borrow_d     = borrow_q;
        partial_d    = partial_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                partial_d = {cell_d, partial_q[WIDTH-1:1]};
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                borrow_d  = cell_bout;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: the freshly produced MSB completes the result.
                    diff_d       = {cell_d, partial_q[WIDTH-1:1]};
                    borrow_out_d = cell_bout;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears the result.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the whole datapath is reset, not just the FSM, so an aborted op leaves diff=0.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            borrow_q     <= 1'b0;
            partial_q    <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            borrow_q     <= borrow_d;
            partial_q    <= partial_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    // Outputs come straight from registers or decoded state only.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: one 8-bit and one 16-bit instance, an arithmetic-level
// timing model checked every cycle, plus directed hand-computed cases.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Channel 0 drives the WIDTH=8 instance, channel 1 the WIDTH=16 instance.
    logic        start_in [2];
    logic [15:0] a_in     [2];
    logic [15:0] b_in     [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic        borrow_o [2];
    logic [15:0] diff_o   [2];
    logic [7:0]  diff8;
    logic [15:0] diff16;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start_in[0]),
        .a          (a_in[0][7:0]),
        .b          (b_in[0][7:0]),
        .busy       (busy_o[0]),
        .done       (done_o[0]),
        .diff       (diff8),
        .borrow_out (borrow_o[0])
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .start      (start_in[1]),
        .a          (a_in[1]),
        .b          (b_in[1]),
        .busy       (busy_o[1]),
        .done       (done_o[1]),
        .diff       (diff16),
        .borrow_out (borrow_o[1])
    );

    always_comb begin
        diff_o[0] = {8'h00, diff8};
        diff_o[1] = diff16;
    end

    function automatic int wid(input int c);
        return (c == 0) ? 8 : 16;
    endfunction

    function automatic int msk(input int c);
        return (1 << wid(c)) - 1;
    endfunction

    // ---------------- reference model ----------------
    // An accepted operation is a timeline: t counts edges since acceptance,
    // the result appears at t == WIDTH, the unit is free again at t == WIDTH+1.
    bit        m_act  [2];
    int        m_t    [2];
    bit [15:0] m_diff [2];
    bit        m_br   [2];
    bit [15:0] p_diff [2];
    bit        p_br   [2];

    always @(posedge clk or posedge rst) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_act[c]  <= 1'b0;
                m_t[c]    <= 0;
                m_diff[c] <= '0;
                m_br[c]   <= 1'b0;
            end else if (m_act[c]) begin
                m_t[c] <= m_t[c] + 1;
                if (m_t[c] + 1 == wid(c)) begin
                    m_diff[c] <= p_diff[c];
                    m_br[c]   <= p_br[c];
                end
                if (m_t[c] + 1 == wid(c) + 1) m_act[c] <= 1'b0;
            end else if (start_in[c]) begin
                m_act[c]  <= 1'b1;
                m_t[c]    <= 0;
                p_diff[c] <= 16'((int'(a_in[c] & 16'(msk(c))) - int'(b_in[c] & 16'(msk(c)))) & msk(c));
                p_br[c]   <= (a_in[c] & 16'(msk(c))) < (b_in[c] & 16'(msk(c)));
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            logic exp_done;
            exp_done = m_act[c] && (m_t[c] == wid(c));
            n_vec++;
            if (busy_o[c] !== m_act[c] || done_o[c] !== exp_done ||
                diff_o[c] !== m_diff[c] || borrow_o[c] !== m_br[c]) begin
                n_err++;
                $display("FAIL cycle_cmp w%0d @%0t: busy/done/diff/borrow got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                         wid(c), $time, busy_o[c], done_o[c], diff_o[c], borrow_o[c],
                         m_act[c], exp_done, m_diff[c], m_br[c]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one operation from IDLE and follow it to completion (bounded).
    task automatic run_op(input int c, input int ai, input int bi,
                          output int d, output int br, output int lat, output int nbusy);
        @(negedge clk);
        a_in[c]     = 16'(ai & msk(c));
        b_in[c]     = 16'(bi & msk(c));
        start_in[c] = 1'b1;
        @(negedge clk);
        start_in[c] = 1'b0;
        lat = -1; nbusy = 0; d = 0; br = 0;
        for (int t = 0; t < 40; t++) begin
            if (busy_o[c]) nbusy++;
            if (done_o[c]) begin
                lat = t;
                d   = int'(diff_o[c]);
                br  = int'(borrow_o[c]);
            end
            if (!busy_o[c]) break;
            @(negedge clk);
        end
        if (lat < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL op_timeout w%0d: got no done expected done within 40 cycles", wid(c));
        end
    endtask

    task automatic op_expect(input string name, input int c, input int ai, input int bi,
                             input int exp_d, input int exp_br);
        int d, br, lat, nb;
        run_op(c, ai, bi, d, br, lat, nb);
        check({name, "_diff"}, d, exp_d);
        check({name, "_borrow"}, br, exp_br);
        check({name, "_latency"}, lat, wid(c));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int d, br, lat, nb, dones, last, pulses, ai, bi;
        for (int c = 0; c < 2; c++) begin
            start_in[c] = 1'b0;
            a_in[c]     = '0;
            b_in[c]     = '0;
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            check("reset_busy",   int'(busy_o[c]),   0);
            check("reset_done",   int'(done_o[c]),   0);
            check("reset_diff",   int'(diff_o[c]),   0);
            check("reset_borrow", int'(borrow_o[c]), 0);
        end
        #2 rst = 1'b0;

        // Basic: latency 8 and busy for 9 sampled cycles.
        run_op(0, 100, 37, d, br, lat, nb);
        check("basic_diff", d, 63);
        check("basic_borrow", br, 0);
        check("basic_latency", lat, 8);
        check("basic_busy_cycles", nb, 9);

        op_expect("under_5_10",   0, 5,    10,   251, 1);
        op_expect("under_0_255",  0, 0,    255,  1,   1);
        op_expect("edge_255_0",   0, 255,  0,    255, 0);
        op_expect("edge_5a_5a",   0, 'h5A, 'h5A, 0,   0);
        op_expect("w16_1234_4321", 1, 'h1234, 'h4321, 'hCF13, 1);
        op_expect("w16_ffff_1",   1, 'hFFFF, 1,   'hFFFE, 0);

        // Start during SHIFT is ignored: one done, first operands win.
        @(negedge clk);
        a_in[0] = 16'd20; b_in[0] = 16'd3; start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        a_in[0] = 16'd1; b_in[0] = 16'd2; start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        dones = 0; d = -1; br = -1;
        for (int i = 0; i < 25; i++) begin
            if (done_o[0]) begin
                dones++;
                d  = int'(diff_o[0]);
                br = int'(borrow_o[0]);
            end
            @(negedge clk);
        end
        check("ignored_start_dones", dones, 1);
        check("ignored_start_diff", d, 17);
        check("ignored_start_borrow", br, 0);

        // Reset mid-operation wipes the previous result and suppresses done.
        op_expect("pre_reset_200_1", 0, 200, 1, 199, 0);
        @(negedge clk);
        a_in[0] = 16'd50; b_in[0] = 16'd60; start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy",   int'(busy_o[0]),   0);
        check("midreset_done",   int'(done_o[0]),   0);
        check("midreset_diff",   int'(diff_o[0]),   0);
        check("midreset_borrow", int'(borrow_o[0]), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        check("midreset_no_done", dones, 0);
        check("midreset_diff_held", int'(diff_o[0]), 0);
        op_expect("post_reset_9_4", 0, 9, 4, 5, 0);

        // start held high: re-trigger every 10 cycles at WIDTH=8.
        last = -1; pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done_o[0]) begin
                if (last >= 0) check("b2b_period", i - last, 10);
                last = i;
                pulses++;
            end
            start_in[0] = 1'b1;
            a_in[0] = 16'($urandom_range(0, 255));
            b_in[0] = 16'($urandom_range(0, 255));
        end
        check("b2b_pulses", pulses, 4);
        @(negedge clk);
        start_in[0] = 1'b0;
        repeat (15) @(negedge clk);

        // Random operands on both widths.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 1000; i++) begin
                ai = int'($urandom_range(0, msk(c)));
                bi = int'($urandom_range(0, msk(c)));
                run_op(c, ai, bi, d, br, lat, nb);
                check("rand_diff", d, (ai - bi) & msk(c));
                check("rand_borrow", br, (ai < bi) ? 1 : 0);
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell plus a borrow flip-flop. It is the sequential counterpart to the combinational ripple adder datapath in the lab arithmetic set. It sits behind a start/done handshake so a controller can trade latency for area.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits (≥ 2).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request an operation; sampled only in IDLE.
- `a`, input, `WIDTH`: minuend, captured on the accepting edge.
- `b`, input, `WIDTH`: subtrahend, captured on the accepting edge.
- `busy`, output, 1: high while in SHIFT or DONE.
- `done`, output, 1: one-cycle pulse; `diff` and `borrow_out` are valid.
- `diff`, output, `WIDTH`: result `(a - b) mod 2^WIDTH`; held until the next completion.
- `borrow_out`, output, 1: final borrow, 1 iff `a < b` (unsigned); held with `diff`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start=1`: load `a` and `b` into shift registers, clear the borrow flop, clear the bit counter `cnt` to 0, go to SHIFT.
  - `start=0`: stay in IDLE.
- SHIFT, one bit per cycle:
  - Cell inputs are `x=a_sr[0]`, `y=b_sr[0]`, `bin=borrow`.
  - `d = x ^ y ^ bin`.
  - `bout = (~x & y) | (~(x ^ y) & bin)`.
  - Shift `d` into the MSB of a partial-result register; shift `a_sr` and `b_sr` right; `borrow <= bout`; `cnt <= cnt+1`.
  - When `cnt == WIDTH-1`: load `diff <= {d, partial[WIDTH-1:1]}` and `borrow_out <= bout`, then go to DONE.
- DONE: `done=1` for exactly one cycle, then go unconditionally to IDLE.
- `start` is ignored in SHIFT and DONE. Operands are not re-sampled. No queuing.
- Width rules:
  - `cnt` is `$clog2(WIDTH)` bits.
  - Arithmetic is unsigned modulo `2^WIDTH`. The signed interpretation of `diff` is valid when no signed overflow occurs; overflow is not flagged.
- Reset, asynchronous:
  - State IDLE; `cnt`, shift registers, borrow flop, `diff`, `borrow_out` all 0.
  - `busy=0`, `done=0`.
  - Reset mid-operation aborts it: no `done` pulse, and the previous result is lost (`diff=0`).

## Timing
- Start accepted on edge k (IDLE, `start=1`):
  - After edge k: `busy=1`.
  - Edges k+1 … k+WIDTH: process bits 0 … WIDTH-1.
  - After edge k+WIDTH: state DONE, `done=1`, `diff` and `borrow_out` updated.
  - After edge k+WIDTH+1: IDLE, `busy=0`, `done=0`.
- Latency from the accepting edge to `done` is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles at best. `start` held high continuously re-triggers on the first IDLE cycle.
- `busy`, `done`, `diff`, `borrow_out` are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- `diff` and `borrow_out` change only on the DONE-entry edge or on reset.

## Structure
- Package `serial_sub_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t`.
  - Default-width constant `SUB_WIDTH_DEFAULT = 8`.
- Sub-module `full_subtractor`: combinational cell with ports `x`, `y`, `bin` in and `d`, `bout` out. It is instantiated once in the datapath.
- Top level holds the FSM, counter, shift registers, borrow flop and result registers.

## Test plan
- Basic, `WIDTH=8`: `a=100`, `b=37`, start pulse → `done` exactly 8 cycles after the accepting edge, `diff=63`, `borrow_out=0`, `busy` high for 9 cycles.
- Underflow: `a=5`, `b=10` → `diff=251` (0xFB), `borrow_out=1`. Also `a=0`, `b=255` → `diff=1`, `borrow_out=1`.
- Edge operands:
  - `a=255`, `b=0` → `diff=255`, `borrow_out=0`.
  - `a=b=0x5A` → `diff=0`, `borrow_out=0`.
- Ignored start: start with `a=20`, `b=3`; at cycle 3 pulse `start` with `a=1`, `b=2` → result `diff=17`, `borrow_out=0`, only one `done` pulse.
- Reset mid-op:
  - Complete `200-1` (`diff=199`).
  - Start `50-60`, assert `rst` at cycle 4 → `busy`, `done`, `diff`, `borrow_out` all 0 immediately (asynchronously), no `done` afterwards.
  - Next start `9-4` → `diff=5`.
- Back-to-back and randomized: `start` held high → operations restart on every IDLE cycle, period 10 cycles at `WIDTH=8`. 1000 random operand pairs at `WIDTH=8` and `WIDTH=16` checked against `(a-b) mod 2^WIDTH` and `a<b`.
